ppu_vram_responder: RTL
=======================

Name: ppu_vram_responder

Overview:
- Memory-side responder on the PPU video bus; the other end of the background/sprite fetch path.
- Latches the multiplexed low address byte on ALE and decodes the 14-bit PPU address.
- Maps nametable space onto 2 KiB internal CIRAM using selectable mirroring, and serves CHR pattern data from an 8 KiB array.
- Returns read data one clock-enabled cycle after the read strobe is sampled, matching the PPU's two-cycle access (address + rd_n, then sample).

Parameters:
- CHR_ADDR_WIDTH, 13: CHR array address width (8 KiB).
- CIRAM_ADDR_WIDTH, 11: nametable RAM address width (2 KiB).
- CHR_IS_RAM, 1: 1 = CHR writable from the PPU bus; 0 = CHR is ROM and PPU writes are dropped.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_ce  in  1  clock enable (PPU dot rate); all state advances only when i_ce=1
- i_ale  in  1  address latch enable; latch i_ad as address bits [7:0]
- i_ad  in  8  multiplexed address low byte / write data
- i_pa  in  6  address bits [13:8]
- i_rd_n  in  1  read strobe, active low
- i_wr_n  in  1  write strobe, active low
- i_mirroring  in  2  0=horizontal, 1=vertical, 2=single-screen A, 3=single-screen B
- i_chr_load_we  in  1  host CHR preload write (ignores i_ce and CHR_IS_RAM)
- i_chr_load_addr  in  13  host preload address
- i_chr_load_data  in  8  host preload data
- o_data  out  8  read data to PPU
- o_data_valid  out  1  one-ce-cycle pulse when o_data is updated
- o_bus_error  out  1  one-ce-cycle pulse on illegal access
- o_debug_read_count  out  16  count of completed reads

Behaviour:
- Reset: o_data=0, o_data_valid=0, o_bus_error=0, o_debug_read_count=0, address latch=0, previous-strobe registers=1, state IDLE. CHR and CIRAM contents are not cleared.
- Address latch:
  - On i_ce && i_ale, latch[7:0] <= i_ad.
  - Effective address = {i_pa, latch}.
  - If i_ale and a strobe edge occur in the same ce cycle, the effective address uses i_ad directly (bypass).
- Decode:
  - 0x0000–0x1FFF: CHR[addr[12:0]].
  - 0x2000–0x3EFF: CIRAM. Bit 12 is ignored, so 0x3000–0x3EFF mirrors 0x2000–0x2EFF.
  - CIRAM index = {A10', addr[9:0]}, where A10' = addr[11] (horizontal), addr[10] (vertical), 0 (single A), 1 (single B).
  - 0x3F00–0x3FFF: palette space, internal to the PPU, not served. A read returns 0x00 with o_data_valid=1; a write is ignored. Neither raises o_bus_error.
- FSM, with states IDLE, READ, WRITE, advancing on i_ce only:
  - IDLE->READ on a sampled i_rd_n falling edge (prev=1, now=0). The array is read using the effective address at that edge.
  - READ->IDLE on the next ce cycle: o_data <= array word, o_data_valid=1 for that ce cycle, read_count += 1 (wraps 0xFFFF->0).
  - IDLE->WRITE on an i_wr_n falling edge. The array is written with i_ad on that edge.
  - WRITE->IDLE on the next ce cycle.
  - If CHR_IS_RAM=0 and the address is below 0x2000, the write is dropped and o_bus_error pulses.
- Strobe rules:
  - One access per falling edge; holding the strobe low does not re-trigger.
  - A falling edge that arrives while in READ or WRITE is ignored.
  - i_rd_n and i_wr_n both low on the same edge: the write wins, the read is dropped, o_bus_error pulses.
- o_data holds its last value between reads.
- i_chr_load_we writes CHR on any clock edge and takes priority over a same-cycle PPU CHR write.
- i_reset asserted during READ: returns to IDLE, no o_data_valid pulse, counter cleared.

Decomposition:
- Shared package ppu_bus_pkg:
  - Mirroring enum (MIRROR_HORIZONTAL/VERTICAL/SINGLE_A/SINGLE_B).
  - Address-range constants (CHR_END=0x1FFF, NT_BASE=0x2000, PALETTE_BASE=0x3F00).
  - FSM state constants.
- Sub-module ppu_nametable_mirror: combinational {addr[11:10], mirroring} -> A10'.

Test Plan:
- Preload CHR[0x0010]=0xA5; ALE with i_ad=0x10, i_pa=0x00, rd_n low -> next ce cycle o_data=0xA5, o_data_valid=1 for exactly one ce cycle, read_count=1.
- Vertical mirroring: write 0x3C to 0x2005, read 0x2805 -> 0x3C. Horizontal mirroring: the same read returns the CIRAM word at index 0x405, not 0x3C.
- Write 0x77 to 0x3123, read 0x2123 -> 0x77. Read 0x3F01 -> 0x00, o_data_valid=1, o_bus_error=0.
- CHR_IS_RAM=0: write 0xFF to 0x0010 (preloaded 0xA5) -> o_bus_error pulses; a subsequent read returns 0xA5.
- rd_n held low for 5 ce cycles -> exactly one o_data_valid pulse. i_ce=0 throughout a strobe edge -> no access.
- Assert i_reset in the READ state -> no valid pulse, o_data=0, count=0. rd_n and wr_n low together -> write occurs, o_bus_error=1, no valid pulse.

Source files
------------

// File: rtl/ppu_bus_pkg.sv
// Shared PPU video-bus definitions: mirroring modes, address map, responder states.
package ppu_bus_pkg;

  typedef enum logic [1:0] {
    MIRROR_HORIZONTAL = 2'd0,
    MIRROR_VERTICAL   = 2'd1,
    MIRROR_SINGLE_A   = 2'd2,
    MIRROR_SINGLE_B   = 2'd3
  } mirror_e;

  localparam logic [13:0] CHR_END      = 14'h1FFF;
  localparam logic [13:0] NT_BASE      = 14'h2000;
  localparam logic [13:0] PALETTE_BASE = 14'h3F00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } ppu_state_e;

endpackage

// File: rtl/ppu_nametable_mirror.sv
// Selects CIRAM bank bit A10' from PPU address bits [11:10] and the mirroring mode.
module ppu_nametable_mirror
  import ppu_bus_pkg::*;
(
  input  logic [1:0] i_addr_hi,
  input  logic [1:0] i_mirroring,
  output logic       o_a10
);

  always_comb begin
    o_a10 = 1'b0;
    case (mirror_e'(i_mirroring))
      MIRROR_HORIZONTAL: o_a10 = i_addr_hi[1];
      MIRROR_VERTICAL:   o_a10 = i_addr_hi[0];
      MIRROR_SINGLE_A:   o_a10 = 1'b0;
      MIRROR_SINGLE_B:   o_a10 = 1'b1;
    endcase
  end

endmodule

// File: rtl/ppu_vram_responder.sv
// Memory-side PPU bus responder: CHR pattern array plus mirrored 2 KiB CIRAM,
// answering each read strobe falling edge one ce cycle later.
module ppu_vram_responder
  import ppu_bus_pkg::*;
#(
  parameter int CHR_ADDR_WIDTH   = 13,
  parameter int CIRAM_ADDR_WIDTH = 11,
  parameter int CHR_IS_RAM       = 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_ce,
  input  logic                      i_ale,
  input  logic [7:0]                i_ad,
  input  logic [5:0]                i_pa,
  input  logic                      i_rd_n,
  input  logic                      i_wr_n,
  input  logic [1:0]                i_mirroring,
  input  logic                      i_chr_load_we,
  input  logic [CHR_ADDR_WIDTH-1:0] i_chr_load_addr,
  input  logic [7:0]                i_chr_load_data,
  output logic [7:0]                o_data,
  output logic                      o_data_valid,
  output logic                      o_bus_error,
  output logic [15:0]               o_debug_read_count
);

  logic [7:0] chr_mem   [0:(1<<CHR_ADDR_WIDTH)-1];
  logic [7:0] ciram_mem [0:(1<<CIRAM_ADDR_WIDTH)-1];

  ppu_state_e state_q, state_d;
  logic [7:0]  latch_q, latch_d;
  logic        prev_rd_q, prev_rd_d, prev_wr_q, prev_wr_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d, err_q, err_d;
  logic [15:0] count_q, count_d;
  logic        sel_pal_q, sel_pal_d, sel_chr_q, sel_chr_d;
  logic [7:0]  chr_rdata_q, ciram_rdata_q;

  logic [13:0] addr;
  logic        rd_fall, wr_fall, is_chr, is_pal, is_nt, a10;
  logic        rd_en, chr_we, ciram_we;
  logic [CIRAM_ADDR_WIDTH-1:0] ciram_idx;

  // ALE in the same ce cycle as a strobe must use the bus byte directly.
  assign addr    = {i_pa, (i_ale ? i_ad : latch_q)};
  assign rd_fall = prev_rd_q & ~i_rd_n;
  assign wr_fall = prev_wr_q & ~i_wr_n;
  assign is_chr  = (addr <= CHR_END);
  assign is_pal  = (addr >= PALETTE_BASE);
  assign is_nt   = (addr >= NT_BASE) && !is_pal;

  ppu_nametable_mirror u_mirror (
    .i_addr_hi   (addr[11:10]),
    .i_mirroring (i_mirroring),
    .o_a10       (a10)
  );

  assign ciram_idx = {a10, addr[9:0]};

  assign rd_en    = i_ce && (state_q == ST_IDLE) && rd_fall && !wr_fall;
  assign chr_we   = i_ce && (state_q == ST_IDLE) && wr_fall && is_chr && (CHR_IS_RAM != 0);
  assign ciram_we = i_ce && (state_q == ST_IDLE) && wr_fall && is_nt;

  // Host preload owns the single CHR write port when both want it.
  always_ff @(posedge i_clk) begin
    if (i_chr_load_we)
      chr_mem[i_chr_load_addr] <= i_chr_load_data;
    else if (chr_we)
      chr_mem[addr[CHR_ADDR_WIDTH-1:0]] <= i_ad;
    if (ciram_we)
      ciram_mem[ciram_idx] <= i_ad;
    if (rd_en) begin
      chr_rdata_q   <= chr_mem[addr[CHR_ADDR_WIDTH-1:0]];
      ciram_rdata_q <= ciram_mem[ciram_idx];
    end
  end

  always_comb begin
    state_d   = state_q;
    latch_d   = latch_q;
    prev_rd_d = prev_rd_q;
    prev_wr_d = prev_wr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    err_d     = err_q;
    count_d   = count_q;
    sel_pal_d = sel_pal_q;
    sel_chr_d = sel_chr_q;
    if (i_ce) begin
      valid_d   = 1'b0;
      err_d     = 1'b0;
      prev_rd_d = i_rd_n;
      prev_wr_d = i_wr_n;
      if (i_ale)
        latch_d = i_ad;
      case (state_q)
        ST_IDLE: begin
          if (wr_fall) begin
            state_d = ST_WRITE;
            err_d   = rd_fall || (is_chr && (CHR_IS_RAM == 0));
          end else if (rd_fall) begin
            state_d   = ST_READ;
            sel_pal_d = is_pal;
            sel_chr_d = is_chr;
          end
        end
        ST_READ: begin
          data_d  = sel_pal_q ? 8'h00 : (sel_chr_q ? chr_rdata_q : ciram_rdata_q);
          valid_d = 1'b1;
          count_d = count_q + 16'd1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      latch_q   <= 8'h00;
      prev_rd_q <= 1'b1;
      prev_wr_q <= 1'b1;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= 16'h0000;
      sel_pal_q <= 1'b0;
      sel_chr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      latch_q   <= latch_d;
      prev_rd_q <= prev_rd_d;
      prev_wr_q <= prev_wr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      count_q   <= count_d;
      sel_pal_q <= sel_pal_d;
      sel_chr_q <= sel_chr_d;
    end
  end

  assign o_data             = data_q;
  assign o_data_valid       = valid_q;
  assign o_bus_error        = err_q;
  assign o_debug_read_count = count_q;

endmodule
